decode_stage: RTL

- Pipeline stage directly downstream of the fetch stage.
- Captures the fetched instruction and PC in an IF/ID register with stall and flush control.
- Decodes fields, generates the sign-extended immediate and flags illegal opcodes.
- Holds the 32x32 integer register file, with a write-back port and write-through bypass.
- Drives operands and control fields to the execute stage.

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/regfile.sv | 50 +++++
 rtl/decode_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode constants, NOP encoding and immediate-format helpers
package riscv_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] FENCE  = 7'b0001111;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] opc);
    case (opc)
      OP_IMM, LOAD, JALR: imm_type_of = IMM_I;
      STORE:              imm_type_of = IMM_S;
      BRANCH:             imm_type_of = IMM_B;
      LUI, AUIPC:         imm_type_of = IMM_U;
      JAL:                imm_type_of = IMM_J;
      default:            imm_type_of = IMM_NONE;
    endcase
  endfunction

  function automatic logic is_legal_opcode(input logic [6:0] opc);
    case (opc)
      OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP, SYSTEM, FENCE:
        is_legal_opcode = 1'b1;
      default:
        is_legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 32-entry integer register file, two async reads, one sync write, write-through bypass
module regfile #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [32];
  logic            wr_hit;

  assign wr_hit = we_i && (waddr_i != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_hit) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // x0 is never written, but reads are forced to zero so a bypass on x0 can't leak through.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == 5'd0) begin
      rdata1_o = '0;
    end else if (wr_hit && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == 5'd0) begin
      rdata2_o = '0;
    end else if (wr_hit && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - IF/ID register, field decode, immediate generation and register-file read
module decode_stage #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR,
  parameter logic [XLEN-1:0]  PC_RESET  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic [6:0]      opcode_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  import riscv_pkg::*;

  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [31:0]     imm32;

  // Flush outranks stall so a squashed slot never survives a stalled cycle.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      pc_d    = pc_i;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= PC_RESET;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign instr_o    = instr_q;
  assign opcode_o   = instr_q[6:0];
  assign rd_o       = instr_q[11:7];
  assign funct3_o   = instr_q[14:12];
  assign rs1_addr_o = instr_q[19:15];
  assign rs2_addr_o = instr_q[24:20];
  assign funct7_o   = instr_q[31:25];

  always_comb begin
    imm32 = 32'd0;
    case (imm_type_of(instr_q[6:0]))
      IMM_I: imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
      IMM_S: imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      IMM_B: imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                      instr_q[11:8], 1'b0};
      IMM_U: imm32 = {instr_q[31:12], 12'd0};
      IMM_J: imm32 = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                      instr_q[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm_o     = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
  assign illegal_o = valid_q && !is_legal_opcode(instr_q[6:0]);

  regfile #(
    .XLEN(XLEN)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_en_i),
    .waddr_i  (wb_addr_i),
    .wdata_i  (wb_data_i),
    .raddr1_i (instr_q[19:15]),
    .raddr2_i (instr_q[24:20]),
    .rdata1_o (rs1_data_o),
    .rdata2_o (rs2_data_o)
  );

endmodule
